// File: rtl/defines_cnn_core.sv
// ============================================================================
// Module   : defines_cnn_core (shared macro header)
// Brief    : Dimension and width macros shared by the CNN core stages.
// Revision : 1.0 - stage-2 pooling dimensions added
// ============================================================================
`default_nettype none
`ifndef DEFINES_CNN_CORE_SV
`define DEFINES_CNN_CORE_SV

`define ST2_Conv_CO  3
`define ST2_O_F_BW   33
`define ST2_Conv_X   12
`define ST2_Conv_Y   12
`define ST2_KX       5
`define ST2_KY       5
`define ST2_O_X      (`ST2_Conv_X - `ST2_KX + 1)
`define ST2_O_Y      (`ST2_Conv_Y - `ST2_KY + 1)
`define ST2_POOL_X   4
`define ST2_POOL_Y   4

`endif
`default_nettype wire

// File: rtl/stage2_pool_max2.sv
// ============================================================================
// Module   : stage2_pool_max2
// Brief    : Combinational signed maximum of two BW-bit operands.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stage2_pool_max2 #(
  parameter int BW = 32
) (
  input  logic [BW-1:0] a_i,
  input  logic [BW-1:0] b_i,
  output logic [BW-1:0] max_o
);

  assign max_o = ($signed(a_i) >= $signed(b_i)) ? a_i : b_i;

endmodule

`default_nettype wire

// File: rtl/stage2_maxpool.sv
// ============================================================================
// Module   : stage2_maxpool
// Brief    : 2x2 stride-2 streaming max-pool over the stage-2 conv raster.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`ifndef DEFINES_CNN_CORE_SV
`include "defines_cnn_core.sv"
`endif

module stage2_maxpool #(
  parameter int CH   = `ST2_Conv_CO,
  parameter int BW   = `ST2_O_F_BW - 1,
  parameter int IN_X = `ST2_O_X,
  parameter int IN_Y = `ST2_O_Y
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_in_valid,
  input  logic [CH*BW-1:0] i_in_fmap,
  output logic             o_ot_valid,
  output logic [CH*BW-1:0] o_ot_fmap,
  output logic             o_ot_last
);

  localparam int CW = $clog2(IN_X);
  localparam int RW = $clog2(IN_Y);
  localparam int BX = IN_X / 2;

  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [CH*BW-1:0] hold_q;
  logic [CH*BW-1:0] buf_q [BX];
  logic [CH*BW-1:0] fmap_q;
  logic             valid_q;
  logic             last_q;

  logic [CW-2:0]    w_bidx;
  logic             w_col_end;
  logic             w_row_end;
  logic [CH*BW-1:0] w_buf_rd;
  logic [CH*BW-1:0] w_hmax;
  logic [CH*BW-1:0] w_vmax;

  assign w_bidx    = col_q[CW-1:1];
  assign w_col_end = (col_q == CW'(IN_X - 1));
  assign w_row_end = (row_q == RW'(IN_Y - 1));
  assign w_buf_rd  = buf_q[w_bidx];

  // Horizontal max pairs the held even column with the current odd column;
  // vertical max pairs that with the result buffered from the even row.
  generate
    for (genvar c = 0; c < CH; c++) begin : g_ch
      stage2_pool_max2 #(.BW(BW)) u_hmax (
        .a_i   (hold_q[c*BW +: BW]),
        .b_i   (i_in_fmap[c*BW +: BW]),
        .max_o (w_hmax[c*BW +: BW])
      );
      stage2_pool_max2 #(.BW(BW)) u_vmax (
        .a_i   (w_buf_rd[c*BW +: BW]),
        .b_i   (w_hmax[c*BW +: BW]),
        .max_o (w_vmax[c*BW +: BW])
      );
    end
  endgenerate

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (i_in_valid) begin
      if (w_col_end) begin
        col_d = '0;
        row_d = w_row_end ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q   <= '0;
      row_q   <= '0;
      hold_q  <= '0;
      fmap_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      for (int i = 0; i < BX; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      if (i_in_valid) begin
        if (!col_q[0]) begin
          hold_q <= i_in_fmap;
        end else if (!row_q[0]) begin
          buf_q[w_bidx] <= w_hmax;
        end else begin
          fmap_q  <= w_vmax;
          valid_q <= 1'b1;
          last_q  <= w_row_end && w_col_end;
        end
      end
    end
  end

  assign o_ot_valid = valid_q;
  assign o_ot_fmap  = fmap_q;
  assign o_ot_last  = last_q;

endmodule

`default_nettype wire

// File: tb/tb_stage2_maxpool.sv
// ============================================================================
// Module   : tb_stage2_maxpool
// Brief    : Scoreboard bench for stage2_maxpool with directed frames.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stage2_maxpool;

  localparam int CH = 3;
  localparam int BW = 32;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            i_in_valid = 1'b0;
  logic [CH*BW-1:0] i_in_fmap = '0;
  logic            o_ot_valid;
  logic [CH*BW-1:0] o_ot_fmap;
  logic            o_ot_last;

  stage2_maxpool #(.CH(CH), .BW(BW), .IN_X(8), .IN_Y(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_in_valid (i_in_valid),
    .i_in_fmap  (i_in_fmap),
    .o_ot_valid (o_ot_valid),
    .o_ot_fmap  (o_ot_fmap),
    .o_ot_last  (o_ot_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH*BW-1:0] fmap;
    logic             last;
    int               due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // kind 0 ramp, 1 max-position sweep, 2 all fives, 3 signed edge
  function automatic logic [31:0] pix(int kind, int r, int c, int ch);
    int w;
    case (kind)
      0: return (ch == 0) ? 32'(r*8 + c) : (ch == 1) ? 32'(100 + r*8 + c) : 32'd0;
      1: begin
        w = (r/2)*4 + c/2;
        return (((r%2)*2 + (c%2)) == (w%4)) ? 32'd7 : 32'd1;
      end
      2: return 32'd5;
      default: begin
        if (r < 2 && c < 2) begin
          case (r*2 + c)
            0: return 32'h8000_0000;
            1: return 32'h0000_0000;
            2: return 32'h7FFF_FFFF;
            default: return 32'h0000_0001;
          endcase
        end
        if (r < 2 && c < 4) return 32'h8000_0000;
        return 32'(r*c - 3*ch);
      end
    endcase
  endfunction

  function automatic logic [CH*BW-1:0] win_max(int kind, int pr, int pc);
    logic [CH*BW-1:0] res;
    logic signed [31:0] m, v;
    res = '0;
    for (int ch = 0; ch < CH; ch++) begin
      m = pix(kind, 2*pr, 2*pc, ch);
      for (int dy = 0; dy < 2; dy++)
        for (int dx = 0; dx < 2; dx++) begin
          v = pix(kind, 2*pr + dy, 2*pc + dx, ch);
          if (v > m) m = v;
        end
      res[ch*BW +: BW] = m;
    end
    return res;
  endfunction

  // Leaves i_in_valid high after the final point so consecutive calls abut.
  task automatic send_frame(int kind, int maxgap, int npts);
    logic [CH*BW-1:0] d;
    exp_t e;
    for (int n = 0; n < npts; n++) begin
      int r, c;
      r = n / 8;
      c = n % 8;
      for (int ch = 0; ch < CH; ch++) d[ch*BW +: BW] = pix(kind, r, c, ch);
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        e.fmap = win_max(kind, r/2, c/2);
        e.last = (r == 7) && (c == 7);
        e.due  = cyc + 1;
        sb.push_back(e);
      end
      i_in_valid = 1'b1;
      i_in_fmap  = d;
      @(posedge clk);
      #1;
      if (maxgap > 0 && n != npts - 1) begin
        int g;
        g = $urandom_range(0, maxgap);
        i_in_valid = 1'b0;
        repeat (g) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic idle(int n);
    i_in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(string tag);
    @(negedge clk);
    tests++;
    if (o_ot_valid !== 1'b0 || o_ot_last !== 1'b0 || o_ot_fmap !== '0) begin
      fails++;
      $display("FAIL %s: valid=%b last=%b fmap=%h, required valid=0 last=0 fmap=0",
               tag, o_ot_valid, o_ot_last, o_ot_fmap);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        exp_t e;
        e = sb.pop_front();
        tests++;
        fails++;
        $display("FAIL missing_output: no pooled output by cycle %0d, required fmap=%h last=%b at cycle %0d",
                 cyc, e.fmap, e.last, e.due);
      end
      if (o_ot_valid) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL spurious_valid: fmap=%h last=%b at cycle %0d, required no output",
                   o_ot_fmap, o_ot_last, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (o_ot_fmap !== e.fmap || o_ot_last !== e.last || cyc != e.due) begin
            fails++;
            $display("FAIL pooled_output: fmap=%h last=%b cycle=%0d, required fmap=%h last=%b cycle=%0d",
                     o_ot_fmap, o_ot_last, cyc, e.fmap, e.last, e.due);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    check_reset_outputs("reset_state");
    check_reset_outputs("reset_state_hold");
    @(posedge clk);
    #1 reset_n = 1'b1;
    idle(2);

    send_frame(0, 0, 64);   // ramp
    idle(3);
    send_frame(1, 0, 64);   // max-position sweep
    idle(3);
    send_frame(0, 5, 64);   // ramp with random gaps
    idle(3);
    send_frame(0, 0, 64);   // back-to-back: ramp then all fives
    send_frame(2, 0, 64);
    idle(3);
    send_frame(3, 2, 64);   // signed extremes
    idle(3);

    send_frame(0, 0, 37);   // partial frame abandoned by reset
    idle(2);
    reset_n = 1'b0;
    check_reset_outputs("midframe_reset");
    check_reset_outputs("midframe_reset_hold");
    @(posedge clk);
    #1 reset_n = 1'b1;
    idle(1);
    send_frame(0, 0, 64);
    idle(10);

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d outputs still pending, required 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
